timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
Memory-mapped programmable down-counter timer on the CPU's peripheral bus. Software programs a preset value and a control word. On expiry the block raises an interrupt request. That request drives one bit of the 6-bit hardware-interrupt vector consumed by the coprocessor-0 exception unit, so this block sits directly upstream of CP0's interrupt input.

Parameters:
DATA_W, 32, width of bus data, PRESET and COUNT registers

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
addr  in  2  word offset within timer window (0=CTRL, 1=PRESET, 2=COUNT, 3=unused)
we  in  1  bus write strobe, sampled on posedge clk
wdata  in  DATA_W  bus write data
rdata  out  DATA_W  bus read data, combinational on addr
irq  out  1  interrupt request to CP0 HWInt bit

Behaviour:
- Reset, synchronous, active-high, on clock clk. On reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0. rdata follows addr (CTRL/PRESET/COUNT all read 0).
- CTRL fields: [0] EN (enable), [2:1] MODE (00 one-shot; 01 periodic; 10/11 behave as 00), [3] IM (interrupt mask; 1 = allowed). Bits [31:4] are reserved, written as 0 and read as 0.
- Writes (we=1): addr 0 loads CTRL with reserved bits zeroed and clears irq_flag. addr 1 loads PRESET. addr 2 and 3 are ignored; COUNT is read-only.
- A PRESET write never alters COUNT directly. It takes effect at the next LOAD.
- Read mux: addr 0 -> CTRL, 1 -> PRESET, 2 -> COUNT, 3 -> 0.
- irq = irq_flag & CTRL.IM, combinational from registers.
- FSM (registered, one transition per posedge):
  - IDLE: if EN -> LOAD; else stay, COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: if !EN -> IDLE (COUNT frozen). Else if COUNT==0 -> INT and irq_flag <= 1. Else COUNT <= COUNT-1.
  - INT, MODE one-shot: EN <= 0; -> IDLE; irq_flag stays 1 until the next CTRL write or reset.
  - INT, MODE periodic: irq_flag <= 0; -> LOAD. irq is therefore high for exactly one cycle per period.
- Latency: the CTRL write (EN=1) lands at edge E0. State is LOAD after E1, CNT with COUNT=PRESET after E2, and COUNT=0 after E(2+PRESET). INT with irq high follows at E(3+PRESET).
- Periodic period is PRESET+3 cycles.
- PRESET=0: CNT sees COUNT==0 immediately, and INT is entered at E3.
- Simultaneous bus CTRL write and FSM EN-clear in INT: the bus write wins (CTRL = written value). irq_flag is cleared by the write, even if the same edge would set it.
- A CTRL write with EN=0 during CNT: state goes to IDLE on the next edge and COUNT holds its value.
- Re-enabling from IDLE always passes through LOAD; there is no resume from a frozen COUNT.
- Reset mid-count or in INT: all registers return to their reset values, irq drops after that edge, and no pending interrupt is retained.
- COUNT never wraps below 0. Decrement only occurs when COUNT != 0.
- IM=0 masks irq only. irq_flag still sets, and irq appears as soon as IM is set with the flag pending.

Test Plan:
- Reset, then read addr 0/1/2 -> rdata 0/0/0 and irq=0. Write CTRL=0xFFFFFFFF -> CTRL reads 0x0000000F.
- Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT reads 5 after E2 and 0 after E7. irq=1 after E8. CTRL reads 0x8 after E9 and irq stays 1. Writing CTRL=0x8 then drops irq.
- PRESET=2, CTRL=0xB (periodic, IM) -> irq is a 1-cycle pulse after E5, then every 5 cycles, and COUNT reloads to 2 each period.
- PRESET=10, CTRL=0x1 (IM=0) -> expiry after E13 with irq=0. Writing CTRL=0x8 clears the flag, so irq stays 0. Separately, set IM via PRESET-unaffected path: the flag-pending case shows irq=1 only while IM=1.
- Mid-count (COUNT=4), write CTRL=0x8 -> state IDLE, COUNT holds 4, and no irq. Rewrite CTRL=0x9 -> COUNT reloads from PRESET, not 4.
- Assert reset while in INT with irq=1 -> after that edge irq=0, COUNT=0 and CTRL=0. PRESET=0 with EN -> irq after E3.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with one-shot/periodic modes.
// Raises irq (flag gated by CTRL.IM) on expiry; feeds one CP0 HWInt bit.
module timer_counter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_PERIOD = 2'b01;
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_ctrl;
  logic [3:0]        w_ctrl_nxt;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] w_preset_nxt;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] w_count_nxt;
  logic              r_irq_flag;
  logic              w_irq_flag_nxt;

  logic              w_en;
  logic              w_im;
  logic              w_periodic;
  logic              w_ctrl_wr;
  logic              w_preset_wr;
  logic              w_count_zero;

  assign w_en         = r_ctrl[0];
  assign w_periodic   = (r_ctrl[2:1] == MODE_PERIOD);
  assign w_im         = r_ctrl[3];
  assign w_ctrl_wr    = we && (addr == ADDR_CTRL);
  assign w_preset_wr  = we && (addr == ADDR_PRESET);
  assign w_count_zero = (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_irq_flag <= w_irq_flag_nxt;
    end
  end

  // FSM decides first; a bus CTRL write then overrides both CTRL and the
  // irq flag, so software always wins a same-edge collision with the FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_ctrl_nxt     = r_ctrl;
    w_preset_nxt   = r_preset;
    w_count_nxt    = r_count;
    w_irq_flag_nxt = r_irq_flag;

    unique case (r_state)
      S_IDLE: begin
        if (w_en) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!w_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_count_zero) begin
          w_state_nxt    = S_INT;
          w_irq_flag_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count - ONE;
        end
      end
      S_INT: begin
        if (w_periodic) begin
          w_irq_flag_nxt = 1'b0;
          w_state_nxt    = S_LOAD;
        end else begin
          w_ctrl_nxt[0] = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_ctrl_wr) begin
      w_ctrl_nxt     = wdata[3:0];
      w_irq_flag_nxt = 1'b0;
    end
    if (w_preset_wr) begin
      w_preset_nxt = wdata;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL:   rdata = {{(DATA_W-4){1'b0}}, r_ctrl};
      ADDR_PRESET: rdata = r_preset;
      ADDR_COUNT:  rdata = r_count;
      default:     rdata = '0;
    endcase
  end

  assign irq = r_irq_flag & w_im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: expectations queued as stimulus is
// driven, DUT samples queued as observed, each scenario drains and compares.
`timescale 1ns/1ps
module tb_timer_counter;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  int n_vec = 0;
  int n_err = 0;

  string             exp_name[$];
  logic [DATA_W-1:0] exp_val[$];
  logic [DATA_W-1:0] obs_q[$];

  timer_counter #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic expect_v(input string nm, input logic [DATA_W-1:0] v);
    exp_name.push_back(nm);
    exp_val.push_back(v);
  endtask

  task automatic sample_rd(input logic [1:0] a);
    addr = a;
    #1;
    obs_q.push_back(rdata);
  endtask

  task automatic sample_irq();
    obs_q.push_back({{(DATA_W-1){1'b0}}, irq});
  endtask

  task automatic test_reset();
    string nm;
    logic [DATA_W-1:0] e, o;
    do_reset();
    expect_v("rst_ctrl", 32'h0);   sample_rd(2'd0);
    expect_v("rst_preset", 32'h0); sample_rd(2'd1);
    expect_v("rst_count", 32'h0);  sample_rd(2'd2);
    expect_v("rst_irq", 32'h0);    sample_irq();
    bus_write(2'd1, 32'h1234_5678);
    expect_v("preset_rb", 32'h1234_5678); sample_rd(2'd1);
    expect_v("addr3_zero", 32'h0);        sample_rd(2'd3);
    bus_write(2'd0, 32'hFFFF_FFFF);
    expect_v("ctrl_reserved", 32'h0000_000F); sample_rd(2'd0);
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_oneshot();
    string nm;
    logic [DATA_W-1:0] e, o;
    do_reset();
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);                      // E0
    tick(2);
    expect_v("os_count_e2", 32'd5);  sample_rd(2'd2);
    tick(5);
    expect_v("os_count_e7", 32'd0);  sample_rd(2'd2);
    expect_v("os_irq_e7", 32'd0);    sample_irq();
    tick(1);
    expect_v("os_irq_e8", 32'd1);    sample_irq();
    tick(1);
    expect_v("os_ctrl_e9", 32'h8);   sample_rd(2'd0);
    expect_v("os_irq_e9", 32'd1);    sample_irq();
    tick(3);
    expect_v("os_irq_hold", 32'd1);  sample_irq();
    expect_v("os_count_hold", 32'd0); sample_rd(2'd2);
    bus_write(2'd0, 32'h8);
    expect_v("os_irq_cleared", 32'd0); sample_irq();
    expect_v("os_ctrl_wr", 32'h8);     sample_rd(2'd0);
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_periodic();
    string nm;
    logic [DATA_W-1:0] e, o;
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'hB);                      // E0
    tick(4);
    expect_v("per_count_e4", 32'd0); sample_rd(2'd2);
    expect_v("per_irq_e4", 32'd0);   sample_irq();
    tick(1);
    expect_v("per_irq_e5", 32'd1);   sample_irq();
    for (int k = 0; k < 3; k++) begin
      tick(1);
      expect_v($sformatf("per_irq_lo%0d", k), 32'd0); sample_irq();
      tick(1);
      expect_v($sformatf("per_reload%0d", k), 32'd2); sample_rd(2'd2);
      tick(3);
      expect_v($sformatf("per_irq_hi%0d", k), 32'd1); sample_irq();
    end
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_masked();
    string nm;
    logic [DATA_W-1:0] e, o;
    do_reset();
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h1);                      // E0, IM=0
    tick(12);
    expect_v("msk_count_e12", 32'd0); sample_rd(2'd2);
    tick(1);
    expect_v("msk_irq_e13", 32'd0);   sample_irq();
    tick(1);
    expect_v("msk_ctrl_e14", 32'h0);  sample_rd(2'd0);
    expect_v("msk_irq_e14", 32'd0);   sample_irq();
    bus_write(2'd0, 32'h8);
    expect_v("msk_irq_after_im", 32'd0); sample_irq();
    tick(3);
    expect_v("msk_irq_later", 32'd0);    sample_irq();
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_stop_restart();
    string nm;
    logic [DATA_W-1:0] e, o;
    do_reset();
    bus_write(2'd1, 32'd8);
    bus_write(2'd0, 32'h9);                      // E0
    tick(5);
    expect_v("stp_count_e5", 32'd5); sample_rd(2'd2);
    bus_write(2'd0, 32'h8);                      // lands at E6, last decrement to 4
    expect_v("stp_count_e6", 32'd4); sample_rd(2'd2);
    tick(4);
    expect_v("stp_count_hold", 32'd4); sample_rd(2'd2);
    expect_v("stp_irq", 32'd0);        sample_irq();
    expect_v("stp_ctrl", 32'h8);       sample_rd(2'd0);
    bus_write(2'd0, 32'h9);                      // F0
    tick(1);
    expect_v("rst_count_f1", 32'd4); sample_rd(2'd2);
    tick(1);
    expect_v("rst_count_f2", 32'd8); sample_rd(2'd2);
    bus_write(2'd1, 32'd3);                      // F3: PRESET write leaves COUNT alone
    expect_v("pre_wr_count", 32'd7); sample_rd(2'd2);
    expect_v("pre_wr_preset", 32'd3); sample_rd(2'd1);
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_reset_in_int();
    string nm;
    logic [DATA_W-1:0] e, o;
    do_reset();
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h9);                      // E0
    tick(4);
    expect_v("ri_irq_pre", 32'd1); sample_irq();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_v("ri_irq", 32'd0);    sample_irq();
    expect_v("ri_count", 32'd0);  sample_rd(2'd2);
    expect_v("ri_ctrl", 32'h0);   sample_rd(2'd0);
    expect_v("ri_preset", 32'h0); sample_rd(2'd1);
    tick(3);
    expect_v("ri_no_pending", 32'd0); sample_irq();
    bus_write(2'd0, 32'h9);                      // PRESET=0, E0
    tick(2);
    expect_v("p0_irq_e2", 32'd0); sample_irq();
    tick(1);
    expect_v("p0_irq_e3", 32'd1); sample_irq();
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    string nm;
    logic [DATA_W-1:0] e, o;
    // Write lands on the same edge the FSM leaves INT (one-shot EN clear).
    do_reset();
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h9);                      // E0
    tick(4);
    expect_v("bb_irq_int", 32'd1); sample_irq();
    bus_write(2'd0, 32'hB);                      // W0 = E5
    expect_v("bb_ctrl_wins", 32'hB); sample_rd(2'd0);
    expect_v("bb_irq_w0", 32'd0);    sample_irq();
    tick(3);
    expect_v("bb_irq_w3", 32'd0);    sample_irq();
    tick(1);
    expect_v("bb_irq_w4", 32'd1);    sample_irq();
    tick(1);
    expect_v("bb_irq_w5", 32'd0);    sample_irq();
    // Write lands on the same edge that would set the flag.
    do_reset();
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h9);                      // E0
    tick(3);
    expect_v("bb2_count_e3", 32'd0); sample_rd(2'd2);
    bus_write(2'd0, 32'h9);                      // E4
    expect_v("bb2_irq_e4", 32'd0);   sample_irq();
    expect_v("bb2_ctrl_e4", 32'h9);  sample_rd(2'd0);
    tick(1);
    expect_v("bb2_ctrl_e5", 32'h8);  sample_rd(2'd0);
    expect_v("bb2_irq_e5", 32'd0);   sample_irq();
    while (exp_val.size() != 0) begin
      nm = exp_name.pop_front();
      e  = exp_val.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: no sample, expected %h", nm, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    tick(1);
    test_reset();
    test_oneshot();
    test_periodic();
    test_masked();
    test_stop_restart();
    test_reset_in_int();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
